// File: rtl/ooo_pkg.sv
// Shared out-of-order core widths and the issue-queue entry record.
// Entry layout is common to every per-FU issue queue instance.
package ooo_pkg;

   localparam int PRN_BITS     = 6;
   localparam int INST_ID_BITS = 6;
   localparam int MAX_OPERANDS = 3;
   localparam int FU_COUNT     = 4;

   typedef struct packed {
      logic                                 valid;
      logic [INST_ID_BITS-1:0]              inst_id;
      logic [31:0]                          raw_instr;
      logic [63:0]                          pc;
      logic [MAX_OPERANDS-1:0]              src_valid;
      logic [MAX_OPERANDS-1:0]              src_ready;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] src_prn;
      logic [MAX_OPERANDS-1:0]              dst_valid;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] dst_prn;
   } iq_entry_t;

endpackage

// File: rtl/iq_select.sv
// Combinational picker: one-hot grant of the oldest requesting entry.
// ISSUE_QUEUE_AGE_ORDER_EN selects age-matrix order, otherwise lowest index wins.
module iq_select #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
   input  logic [N-1:0] age [N],
`endif
   output logic [N-1:0] grant,
   output logic         any
);

`ifdef ISSUE_QUEUE_AGE_ORDER_EN
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         // age[i][j] set means entry i is older than entry j
         always_comb begin
            grant[gi] = req[gi];
            for (int j = 0; j < N; j++) begin
               if (j != gi && req[j] && !age[gi][j]) grant[gi] = 1'b0;
            end
         end
      end
   endgenerate
`else
   assign grant = req & (~req + N'(1));
`endif

   assign any = |req;

endmodule

// File: rtl/issue_queue.sv
// Per-FU issue queue: holds renamed instructions, wakes sources from broadcasts,
// offers the oldest ready entry to the FU. Optional ISSUE_QUEUE_AGE_ORDER_EN.
module issue_queue #(
   parameter int QUEUE_SIZE   = 4,
   parameter int INST_ID_BITS = ooo_pkg::INST_ID_BITS,
   parameter int PRN_BITS     = ooo_pkg::PRN_BITS,
   parameter int MAX_OPERANDS = ooo_pkg::MAX_OPERANDS,
   parameter int FU_COUNT     = ooo_pkg::FU_COUNT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [INST_ID_BITS-1:0] in_inst_id,
   input  logic [31:0]             in_raw_instr,
   input  logic [63:0]             in_instr_pc,
   input  logic [MAX_OPERANDS-1:0] in_prn_input_valid,
   input  logic [MAX_OPERANDS-1:0] in_prn_input_ready,
   input  logic [PRN_BITS-1:0]     in_prn_input [MAX_OPERANDS],
   input  logic [MAX_OPERANDS-1:0] in_prn_output_valid,
   input  logic [PRN_BITS-1:0]     in_prn_output [MAX_OPERANDS],
   output logic                    queue_ready,
   input  logic [MAX_OPERANDS-1:0] set_prn_ready [FU_COUNT],
   input  logic [PRN_BITS-1:0]     set_prn [FU_COUNT][MAX_OPERANDS],
   input  logic                    flush,
   output logic                    issue_valid,
   input  logic                    fu_ready,
   output logic [INST_ID_BITS-1:0] issue_inst_id,
   output logic [31:0]             issue_raw_instr,
   output logic [63:0]             issue_instr_pc,
   output logic [MAX_OPERANDS-1:0] issue_prn_input_valid,
   output logic [PRN_BITS-1:0]     issue_prn_input [MAX_OPERANDS],
   output logic [MAX_OPERANDS-1:0] issue_prn_output_valid,
   output logic [PRN_BITS-1:0]     issue_prn_output [MAX_OPERANDS]
);
   import ooo_pkg::*;

   iq_entry_t             entry_reg  [QUEUE_SIZE];
   iq_entry_t             entry_next [QUEUE_SIZE];
   iq_entry_t             new_entry;
   logic [QUEUE_SIZE-1:0] valid_vec, free_vec, free_onehot, cand_vec, grant;
   logic                  any_cand, fire, do_insert;

   function automatic logic bcast_hit(input logic [PRN_BITS-1:0] prn);
      logic hit;
      hit = 1'b0;
      for (int f = 0; f < FU_COUNT; f++)
         for (int k = 0; k < MAX_OPERANDS; k++)
            if (set_prn_ready[f][k] && set_prn[f][k] == prn) hit = 1'b1;
      return hit;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < QUEUE_SIZE; gi++) begin : g_entry
         assign valid_vec[gi] = entry_reg[gi].valid;
         assign cand_vec[gi]  = entry_reg[gi].valid && (&entry_reg[gi].src_ready);
      end
   endgenerate

   assign free_vec    = ~valid_vec;
   assign free_onehot = free_vec & (~free_vec + QUEUE_SIZE'(1));
   assign queue_ready = |free_vec;
   assign issue_valid = any_cand && !flush;
   assign fire        = issue_valid && fu_ready;
   assign do_insert   = in_valid && queue_ready && !flush;

`ifdef ISSUE_QUEUE_AGE_ORDER_EN
   logic [QUEUE_SIZE-1:0] age_reg  [QUEUE_SIZE];
   logic [QUEUE_SIZE-1:0] age_next [QUEUE_SIZE];

   // A new entry is younger than every entry still valid before the edge
   always_comb begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         age_next[i] = age_reg[i];
         for (int j = 0; j < QUEUE_SIZE; j++) begin
            if (do_insert && free_onehot[i])      age_next[i][j] = 1'b0;
            else if (do_insert && free_onehot[j]) age_next[i][j] = valid_vec[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_SIZE; i++) age_reg[i] <= rst ? '0 : age_next[i];
   end

   iq_select #(.N(QUEUE_SIZE)) u_select (
      .req(cand_vec), .age(age_reg), .grant(grant), .any(any_cand));
`else
   iq_select #(.N(QUEUE_SIZE)) u_select (
      .req(cand_vec), .grant(grant), .any(any_cand));
`endif

   // Same-cycle broadcast counts as ready so a wakeup is never lost at insert
   always_comb begin
      new_entry           = '0;
      new_entry.valid     = 1'b1;
      new_entry.inst_id   = in_inst_id;
      new_entry.raw_instr = in_raw_instr;
      new_entry.pc        = in_instr_pc;
      new_entry.src_valid = in_prn_input_valid;
      new_entry.dst_valid = in_prn_output_valid;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         new_entry.src_prn[k]   = in_prn_input[k];
         new_entry.dst_prn[k]   = in_prn_output[k];
         new_entry.src_ready[k] = in_prn_input_ready[k] || !in_prn_input_valid[k] ||
                                  bcast_hit(in_prn_input[k]);
      end
   end

   always_comb begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         entry_next[i] = entry_reg[i];
         for (int k = 0; k < MAX_OPERANDS; k++)
            if (entry_reg[i].src_valid[k] && bcast_hit(entry_reg[i].src_prn[k]))
               entry_next[i].src_ready[k] = 1'b1;
         if (fire && grant[i])            entry_next[i].valid = 1'b0;
         if (do_insert && free_onehot[i]) entry_next[i] = new_entry;
         if (flush)                       entry_next[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < QUEUE_SIZE; i++) entry_reg[i] <= rst ? '0 : entry_next[i];
   end

   // AND-OR mux on the one-hot grant; all zero when nothing is selected
   always_comb begin
      issue_inst_id          = '0;
      issue_raw_instr        = '0;
      issue_instr_pc         = '0;
      issue_prn_input_valid  = '0;
      issue_prn_output_valid = '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
         issue_prn_input[k]  = '0;
         issue_prn_output[k] = '0;
      end
      for (int i = 0; i < QUEUE_SIZE; i++) begin
         if (grant[i]) begin
            issue_inst_id          = issue_inst_id | entry_reg[i].inst_id;
            issue_raw_instr        = issue_raw_instr | entry_reg[i].raw_instr;
            issue_instr_pc         = issue_instr_pc | entry_reg[i].pc;
            issue_prn_input_valid  = issue_prn_input_valid | entry_reg[i].src_valid;
            issue_prn_output_valid = issue_prn_output_valid | entry_reg[i].dst_valid;
            for (int k = 0; k < MAX_OPERANDS; k++) begin
               issue_prn_input[k]  = issue_prn_input[k] | entry_reg[i].src_prn[k];
               issue_prn_output[k] = issue_prn_output[k] | entry_reg[i].dst_prn[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Issue queue bench: directed scenarios then random traffic against a
// slot/timestamp reference model. Honours ISSUE_QUEUE_AGE_ORDER_EN.
module tb_issue_queue;

   localparam int QS = 4, IB = 6, PB = 6, MO = 3, FC = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, in_valid, queue_ready, flush, issue_valid, fu_ready;
   logic [IB-1:0] in_inst_id, issue_inst_id;
   logic [31:0]   in_raw_instr, issue_raw_instr;
   logic [63:0]   in_instr_pc, issue_instr_pc;
   logic [MO-1:0] in_prn_input_valid, in_prn_input_ready, in_prn_output_valid;
   logic [MO-1:0] issue_prn_input_valid, issue_prn_output_valid;
   logic [PB-1:0] in_prn_input [MO], in_prn_output [MO];
   logic [PB-1:0] issue_prn_input [MO], issue_prn_output [MO];
   logic [MO-1:0] set_prn_ready [FC];
   logic [PB-1:0] set_prn [FC][MO];

   issue_queue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst_id(in_inst_id),
      .in_raw_instr(in_raw_instr), .in_instr_pc(in_instr_pc),
      .in_prn_input_valid(in_prn_input_valid), .in_prn_input_ready(in_prn_input_ready),
      .in_prn_input(in_prn_input), .in_prn_output_valid(in_prn_output_valid),
      .in_prn_output(in_prn_output), .queue_ready(queue_ready),
      .set_prn_ready(set_prn_ready), .set_prn(set_prn), .flush(flush),
      .issue_valid(issue_valid), .fu_ready(fu_ready), .issue_inst_id(issue_inst_id),
      .issue_raw_instr(issue_raw_instr), .issue_instr_pc(issue_instr_pc),
      .issue_prn_input_valid(issue_prn_input_valid), .issue_prn_input(issue_prn_input),
      .issue_prn_output_valid(issue_prn_output_valid), .issue_prn_output(issue_prn_output));

   int checks = 0, errors = 0, cyc = 0;

   // Reference model: slots with an arrival timestamp for age order
   bit            m_valid [QS];
   logic [IB-1:0] m_id  [QS];
   logic [31:0]   m_raw [QS];
   logic [63:0]   m_pc  [QS];
   logic [MO-1:0] m_sv [QS], m_sr [QS], m_dv [QS];
   logic [PB-1:0] m_sp [QS][MO], m_dp [QS][MO];
   int            m_ts [QS];
   int            ts_next = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit hit(input logic [PB-1:0] prn);
      for (int f = 0; f < FC; f++)
         for (int k = 0; k < MO; k++)
            if (set_prn_ready[f][k] && set_prn[f][k] == prn) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready(input int i);
      if (!m_valid[i]) return 1'b0;
      for (int k = 0; k < MO; k++) if (m_sv[i][k] && !m_sr[i][k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int pick();
      int best = -1;
      for (int i = 0; i < QS; i++) begin
         if (m_ready(i)) begin
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
            if (best < 0 || m_ts[i] < m_ts[best]) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < QS; i++) m_valid[i] = 1'b0;
   endtask

   // Check outputs mid-cycle, advance the model, then cross the clock edge
   task automatic step();
      int idx, slot;
      bit exp_qr, exp_iv;
      #4;
      exp_qr = 1'b0;
      for (int i = 0; i < QS; i++) if (!m_valid[i]) exp_qr = 1'b1;
      idx = pick();
      exp_iv = (idx >= 0) && !flush;
      chk("queue_ready", queue_ready, exp_qr);
      chk("issue_valid", issue_valid, exp_iv);
      if (exp_iv) begin
         chk("issue_inst_id", issue_inst_id, m_id[idx]);
         chk("issue_raw_instr", issue_raw_instr, m_raw[idx]);
         chk("issue_instr_pc", issue_instr_pc, m_pc[idx]);
         chk("issue_prn_input_valid", issue_prn_input_valid, m_sv[idx]);
         chk("issue_prn_output_valid", issue_prn_output_valid, m_dv[idx]);
         for (int k = 0; k < MO; k++) begin
            chk($sformatf("issue_prn_input[%0d]", k), issue_prn_input[k], m_sp[idx][k]);
            chk($sformatf("issue_prn_output[%0d]", k), issue_prn_output[k], m_dp[idx][k]);
         end
      end
      if (rst || flush) begin
         model_clear();
      end else begin
         slot = -1;
         for (int i = 0; i < QS; i++) if (!m_valid[i] && slot < 0) slot = i;
         if (exp_iv && fu_ready) begin
            $display("cycle %0d issue id=%0d", cyc, m_id[idx]);
            m_valid[idx] = 1'b0;
         end
         for (int i = 0; i < QS; i++)
            for (int k = 0; k < MO; k++)
               if (m_valid[i] && m_sv[i][k] && hit(m_sp[i][k])) m_sr[i][k] = 1'b1;
         if (in_valid && slot >= 0) begin
            m_valid[slot] = 1'b1;
            m_id[slot]    = in_inst_id;
            m_raw[slot]   = in_raw_instr;
            m_pc[slot]    = in_instr_pc;
            m_sv[slot]    = in_prn_input_valid;
            m_dv[slot]    = in_prn_output_valid;
            for (int k = 0; k < MO; k++) begin
               m_sp[slot][k] = in_prn_input[k];
               m_dp[slot][k] = in_prn_output[k];
               m_sr[slot][k] = in_prn_input_ready[k] | hit(in_prn_input[k]);
            end
            m_ts[slot] = ts_next;
            ts_next++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b0;
      for (int f = 0; f < FC; f++) set_prn_ready[f] = '0;
   endtask

   task automatic ins(input int id, input logic [MO-1:0] sv, input logic [MO-1:0] sr,
                      input logic [PB-1:0] p0);
      in_valid            = 1'b1;
      in_inst_id          = IB'(id);
      in_raw_instr        = $urandom;
      in_instr_pc         = {$urandom, $urandom};
      in_prn_input_valid  = sv;
      in_prn_input_ready  = sr;
      in_prn_output_valid = MO'($urandom);
      in_prn_input[0]     = p0;
      for (int k = 1; k < MO; k++) in_prn_input[k] = PB'($urandom);
      for (int k = 0; k < MO; k++) in_prn_output[k] = PB'($urandom);
   endtask

   task automatic bc(input int f, input int k, input logic [PB-1:0] prn);
      set_prn_ready[f][k] = 1'b1;
      set_prn[f][k]       = prn;
   endtask

   initial begin
      rst = 1'b1; fu_ready = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_inst_id = '0; in_raw_instr = '0; in_instr_pc = '0;
      in_prn_input_valid = '0; in_prn_input_ready = '0; in_prn_output_valid = '0;
      for (int k = 0; k < MO; k++) begin in_prn_input[k] = '0; in_prn_output[k] = '0; end
      for (int f = 0; f < FC; f++) begin
         set_prn_ready[f] = '0;
         for (int k = 0; k < MO; k++) set_prn[f][k] = '0;
      end
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      idle();

      // Reset state
      #2;
      chk("rst_queue_ready", queue_ready, 1);
      chk("rst_issue_valid", issue_valid, 0);
      chk("rst_issue_inst_id", issue_inst_id, 0);
      chk("rst_issue_raw_instr", issue_raw_instr, 0);
      chk("rst_issue_instr_pc", issue_instr_pc, 0);
      chk("rst_issue_prn_input_valid", issue_prn_input_valid, 0);
      chk("rst_issue_prn_input0", issue_prn_input[0], 0);
      step();

      // All-ready insert issues next cycle and frees the cycle after
      fu_ready = 1'b1;
      ins(5, 3'b001, 3'b001, 6'd3);
      step();
      idle(); #2;
      chk("t1_issue_valid", issue_valid, 1);
      chk("t1_issue_id", issue_inst_id, 5);
      step(); #2;
      chk("t1_freed", issue_valid, 0);
      step();

      // Wakeup by broadcast on FU 2
      ins(1, 3'b001, 3'b000, 6'd12);
      step();
      idle(); #2;
      chk("t2_waiting", issue_valid, 0);
      bc(2, 0, 6'd12);
      step();
      idle(); #2;
      chk("t2_woken_valid", issue_valid, 1);
      chk("t2_woken_id", issue_inst_id, 1);
      step();

      // Same-cycle broadcast at insert; hold with fu_ready low
      fu_ready = 1'b0;
      ins(2, 3'b001, 3'b000, 6'd7);
      bc(1, 1, 6'd7);
      step();
      idle(); #2;
      chk("t3_valid", issue_valid, 1);
      chk("t3_id", issue_inst_id, 2);
      step(); #2;
      chk("t3_stable_valid", issue_valid, 1);
      chk("t3_stable_id", issue_inst_id, 2);
      fu_ready = 1'b1;
      step();

      // Full queue ignores dispatch; one fire reopens it
      fu_ready = 1'b0;
      for (int i = 0; i < QS; i++) begin
         ins(10 + i, 3'b001, 3'b000, PB'(20 + i));
         step();
      end
      idle(); #2;
      chk("t4_full", queue_ready, 0);
      ins(30, 3'b000, 3'b000, 6'd0);
      step();
      idle(); #2;
      chk("t4_ignored", issue_valid, 0);
      bc(0, 2, 6'd20);
      step();
      idle(); fu_ready = 1'b1; #2;
      chk("t4_fire_id", issue_inst_id, 10);
      chk("t4_still_full", queue_ready, 0);
      step(); #2;
      chk("t4_reopened", queue_ready, 1);
      fu_ready = 1'b0; flush = 1'b1;
      step();
      idle();

      // Age order versus index order
      ins(3, 3'b001, 3'b001, 6'd1);
      step();
      ins(4, 3'b001, 3'b000, 6'd40);
      step();
      idle(); fu_ready = 1'b1; #2;
      chk("t5_first_issue", issue_inst_id, 3);
      step();
      fu_ready = 1'b0;
      ins(9, 3'b001, 3'b000, 6'd41);
      step();
      idle();
      bc(0, 0, 6'd40);
      bc(3, 2, 6'd41);
      step();
      idle(); #2;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
      chk("t5_older_first", issue_inst_id, 4);
`else
      chk("t5_lowest_first", issue_inst_id, 9);
`endif
      fu_ready = 1'b1;
      step(); #2;
`ifdef ISSUE_QUEUE_AGE_ORDER_EN
      chk("t5_then", issue_inst_id, 9);
`else
      chk("t5_then", issue_inst_id, 4);
`endif
      step();

      // Flush of a full queue with a ready entry
      fu_ready = 1'b0;
      for (int i = 0; i < QS; i++) begin
         ins(50 + i, 3'b000, 3'b000, 6'd0);
         step();
      end
      idle(); flush = 1'b1; fu_ready = 1'b1; #2;
      chk("t6_flush_blocks_issue", issue_valid, 0);
      chk("t6_full_before", queue_ready, 0);
      step();
      idle(); #2;
      chk("t6_empty_after", queue_ready, 1);
      chk("t6_no_issue_after", issue_valid, 0);
      step();

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         ins($urandom_range(0, 63), MO'($urandom), MO'($urandom & $urandom),
             PB'($urandom_range(0, 15)));
         in_valid = $urandom_range(0, 1);
         for (int k = 0; k < MO; k++) in_prn_input[k] = PB'($urandom_range(0, 15));
         for (int f = 0; f < FC; f++)
            for (int k = 0; k < MO; k++) begin
               set_prn_ready[f][k] = ($urandom_range(0, 4) == 0);
               set_prn[f][k]       = PB'($urandom_range(0, 15));
            end
         fu_ready = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 49) == 0);
         rst      = ($urandom_range(0, 99) == 0);
         step();
      end
      idle();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
